// File: rtl/thresholding_cfg_sequencer.sv
// thresholding_cfg_sequencer
//   Bulk-loads threshold tables into the thresholding core's cfg port from an
//   AXI stream of threshold words, and arbitrates that port with the host
//   (AXI-lite adapter) path. The host always wins and is never stalled.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             begin bulk load (IDLE only) / terminate load
//   busy, done               load in progress / one-cycle completion pulse
//   s_thr_tvalid/tready/tdata   threshold word stream (channel-major order)
//   h_en, h_we, h_a, h_d     host cfg access request
//   h_rack, h_q              host read response (passthrough from core)
//   cfg_en, cfg_we, cfg_a, cfg_d   registered cfg access to the core
//   cfg_rack, cfg_q          core read response
module thresholding_cfg_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned WT = 8,
    parameter int unsigned C  = 4,
    parameter int unsigned PE = 2,
    localparam int unsigned CF      = C / PE,
    localparam int unsigned TA_BITS = $clog2(CF) + $clog2(PE) + N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    input  logic               s_thr_tvalid,
    output logic               s_thr_tready,
    input  logic [WT-1:0]      s_thr_tdata,
    input  logic               h_en,
    input  logic               h_we,
    input  logic [TA_BITS-1:0] h_a,
    input  logic [WT-1:0]      h_d,
    output logic               h_rack,
    output logic [WT-1:0]      h_q,
    output logic               cfg_en,
    output logic               cfg_we,
    output logic [TA_BITS-1:0] cfg_a,
    output logic [WT-1:0]      cfg_d,
    input  logic               cfg_rack,
    input  logic [WT-1:0]      cfg_q
);

    localparam int unsigned T  = (2 ** N) - 1;
    localparam int unsigned PW = (PE > 1) ? $clog2(PE) : 1;
    localparam int unsigned CW = (CF > 1) ? $clog2(CF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   idx, idx_n;
    logic [PW-1:0]  pe, pe_n;
    logic [CW-1:0]  cf, cf_n;

    logic               accept;
    logic               last_word;
    logic [TA_BITS-1:0] load_addr;

    // The loader only ever writes, so every read acknowledge belongs to the host.
    assign h_rack = cfg_rack;
    assign h_q    = cfg_q;

    assign busy         = (state == LOAD);
    assign done         = (state == DONE);
    assign s_thr_tready = (state == LOAD) && !h_en && !abort;
    assign accept       = s_thr_tready && s_thr_tvalid;

    assign last_word = (cf == CW'(CF - 1)) && (pe == PW'(PE - 1)) && (idx == N'(T - 1));

    // Address is {cf, pe, idx}; built by shifting so degenerate CF/PE of 1
    // (zero-width fields) still produce a correct address.
    always_comb begin
        load_addr = (TA_BITS'(cf) << ($clog2(PE) + N))
                  | (TA_BITS'(pe) << N)
                  | TA_BITS'(idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            pe    <= '0;
            cf    <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            pe    <= pe_n;
            cf    <= cf_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        pe_n    = pe;
        cf_n    = cf;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    pe_n    = '0;
                    cf_n    = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    pe_n    = '0;
                    cf_n    = '0;
                end else if (accept) begin
                    // Wrap order: idx innermost, then pe, then cf.
                    if (idx == N'(T - 1)) begin
                        idx_n = '0;
                        if (pe == PW'(PE - 1)) begin
                            pe_n = '0;
                            cf_n = (cf == CW'(CF - 1)) ? '0 : cf + 1'b1;
                        end else begin
                            pe_n = pe + 1'b1;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                    if (last_word) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered cfg port: host request takes precedence; address/data hold
    // their last value when nothing is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_en <= 1'b0;
            cfg_we <= 1'b0;
            cfg_a  <= '0;
            cfg_d  <= '0;
        end else if (h_en) begin
            cfg_en <= 1'b1;
            cfg_we <= h_we;
            cfg_a  <= h_a;
            cfg_d  <= h_d;
        end else if (accept) begin
            cfg_en <= 1'b1;
            cfg_we <= 1'b1;
            cfg_a  <= load_addr;
            cfg_d  <= s_thr_tdata;
        end else begin
            cfg_en <= 1'b0;
            cfg_we <= 1'b0;
        end
    end

endmodule
